// File: rtl/uart_frame_send.sv
// uart_frame_send: 8N1 UART transmitter that sends one 5-byte command frame per request.
// Frame layout: HEADER, cmd, data[15:8], data[7:0], 8-bit additive checksum.
module uart_frame_send #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned UART_BPS = 9600,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send_req,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  output logic        busy,
  output logic        frame_done,
  output logic        uart_txd
);

  localparam int unsigned BPS_CNT  = CLK_FREQ / UART_BPS;
  localparam logic [15:0] BPS_LAST = 16'(BPS_CNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic        txd_d;
  logic        done_d;
  logic        accept;
  logic        bit_end;
  logic [7:0]  sel_byte;

  logic [7:0]  cmd_q;
  logic [15:0] data_q;
  logic [7:0]  csum_q;

  assign bit_end = (clk_cnt_q == BPS_LAST);

  // Next-state, counter and serial-output logic. uart_txd is registered from the
  // next-state view so the start bit appears on the same edge that accepts a request.
  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    done_d     = 1'b0;
    accept     = 1'b0;
    sel_byte   = HEADER;
    txd_d      = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (send_req) begin
          accept     = 1'b1;
          state_d    = START;
          clk_cnt_d  = '0;
          bit_cnt_d  = '0;
          byte_idx_d = '0;
        end
      end
      START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (byte_idx_q == 3'd4) begin
            byte_idx_d = '0;
            state_d    = IDLE;
            done_d     = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            state_d    = START;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
    endcase

    case (byte_idx_d)
      3'd0:    sel_byte = HEADER;
      3'd1:    sel_byte = cmd_q;
      3'd2:    sel_byte = data_q[15:8];
      3'd3:    sel_byte = data_q[7:0];
      default: sel_byte = csum_q;
    endcase

    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = sel_byte[bit_cnt_d];
      default: txd_d = 1'b1;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      uart_txd   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      uart_txd   <= txd_d;
      busy       <= (state_d != IDLE);
      frame_done <= done_d;
    end
  end

  // Capture command, payload and checksum on acceptance only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q  <= '0;
      data_q <= '0;
      csum_q <= '0;
    end else if (accept) begin
      cmd_q  <= cmd;
      data_q <= data;
      csum_q <= HEADER + cmd + data[15:8] + data[7:0];
    end
  end

endmodule

// File: tb/tb_uart_frame_send.sv
// Scoreboard bench for uart_frame_send with BPS_CNT = 10.
module tb_uart_frame_send;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        send_req = 1'b0;
  logic [7:0]  cmd = '0;
  logic [15:0] data = '0;
  logic        busy;
  logic        frame_done;
  logic        uart_txd;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [7:0] byte_q[$];
  int         done_q[$];

  uart_frame_send #(
    .CLK_FREQ(1000),
    .UART_BPS(100),
    .HEADER(8'hA5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .send_req(send_req),
    .cmd(cmd),
    .data(data),
    .busy(busy),
    .frame_done(frame_done),
    .uart_txd(uart_txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_neg(input int n, inout bit alive);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!rst_n) alive = 1'b0;
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push_frame(input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4);
    byte_q.push_back(8'hA5);
    byte_q.push_back(b1);
    byte_q.push_back(b2);
    byte_q.push_back(b3);
    byte_q.push_back(b4);
  endtask

  // Issue a request from a negedge while idle; k is the cycle index right after the accepting edge.
  task automatic request(input logic [7:0] c, input logic [15:0] d, output int k);
    cmd = c;
    data = d;
    send_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    send_req = 1'b0;
    k = cyc;
    check("accept_txd", 32'(uart_txd), 32'd0);
    check("accept_busy", 32'(busy), 32'd1);
  endtask

  // Byte monitor: mid-bit UART receiver that checks each decoded byte against the scoreboard.
  initial begin : byte_mon
    logic [7:0] b;
    logic [7:0] exp_b;
    bit alive;
    logic start_ok;
    logic stop_ok;
    forever begin
      @(negedge clk);
      if (rst_n && uart_txd == 1'b0) begin
        alive = 1'b1;
        b = '0;
        wait_neg(5, alive);
        start_ok = ~uart_txd;
        for (int i = 0; i < 8; i++) begin
          wait_neg(10, alive);
          b[i] = uart_txd;
        end
        wait_neg(10, alive);
        stop_ok = uart_txd;
        if (alive) begin
          check("start_bit", 32'(start_ok), 32'd1);
          check("stop_bit", 32'(stop_ok), 32'd1);
          if (byte_q.size() == 0) begin
            check("unexpected_byte", 32'(b), 32'hFFFF_FFFF);
          end else begin
            exp_b = byte_q.pop_front();
            check("byte", 32'(b), 32'(exp_b));
          end
        end
      end
    end
  end

  // frame_done monitor: every pulse must match the next expected cycle.
  initial begin : done_mon
    int exp_c;
    forever begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        if (done_q.size() == 0) begin
          check("unexpected_frame_done", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          exp_c = done_q.pop_front();
          check("frame_done_time", 32'(cyc), 32'(exp_c));
        end
      end
    end
  end

  initial begin : stim
    int k;
    int errs;
    int guard;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(uart_txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single frame: A5 01 12 34 EC
    push_frame(8'h01, 8'h12, 8'h34, 8'hEC);
    request(8'h01, 16'h1234, k);
    done_q.push_back(k + 500);
    wait_cyc(k + 499);
    check("busy_last", 32'(busy), 32'd1);
    wait_cyc(k + 500);
    check("busy_end", 32'(busy), 32'd0);
    check("txd_end", 32'(uart_txd), 32'd1);
    wait_cyc(k + 501);
    check("done_one_cycle", 32'(frame_done), 32'd0);
    repeat (5) @(negedge clk);

    // Checksum wrap: A5 FF FF FF A2
    push_frame(8'hFF, 8'hFF, 8'hFF, 8'hA2);
    request(8'hFF, 16'hFFFF, k);
    done_q.push_back(k + 500);
    wait_cyc(k + 505);

    // Busy rejection: A5 5A 0F 0F 1D, later requests ignored
    push_frame(8'h5A, 8'h0F, 8'h0F, 8'h1D);
    request(8'h5A, 16'h0F0F, k);
    done_q.push_back(k + 500);
    wait_cyc(k + 100);
    cmd = 8'h77; data = 16'hBEEF; send_req = 1'b1;
    @(negedge clk);
    send_req = 1'b0;
    wait_cyc(k + 300);
    cmd = 8'h11; data = 16'h2233; send_req = 1'b1;
    @(negedge clk);
    send_req = 1'b0;
    wait_cyc(k + 510);
    check("reject_idle_busy", 32'(busy), 32'd0);

    // Back-to-back: A5 10 20 30 05 then A5 80 00 01 26
    push_frame(8'h10, 8'h20, 8'h30, 8'h05);
    push_frame(8'h80, 8'h00, 8'h01, 8'h26);
    cmd = 8'h10; data = 16'h2030; send_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    k = cyc;
    check("b2b_accept_txd", 32'(uart_txd), 32'd0);
    done_q.push_back(k + 500);
    done_q.push_back(k + 1001);
    cmd = 8'h80; data = 16'h0001;
    wait_cyc(k + 500);
    check("b2b_gap_txd", 32'(uart_txd), 32'd1);
    check("b2b_gap_busy", 32'(busy), 32'd0);
    wait_cyc(k + 501);
    check("b2b_second_start", 32'(uart_txd), 32'd0);
    check("b2b_second_busy", 32'(busy), 32'd1);
    wait_cyc(k + 1001);
    send_req = 1'b0;
    wait_cyc(k + 1003);
    check("b2b_after_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);

    // Reset mid-frame: only A5 and 33 complete before the reset
    byte_q.push_back(8'hA5);
    byte_q.push_back(8'h33);
    request(8'h33, 16'h4455, k);
    wait_cyc(k + 237);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_txd", 32'(uart_txd), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(frame_done), 32'd0);
    repeat (4) @(negedge clk);
    check("midrst_bytes_seen", 32'(byte_q.size()), 32'd0);
    rst_n = 1'b1;

    // Idle after reset for 1000 clocks
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) errs++;
    end
    check("idle_quiet", 32'(errs), 32'd0);

    // Fresh frame after reset: A5 C3 3C 00 A4
    push_frame(8'hC3, 8'h3C, 8'h00, 8'hA4);
    request(8'hC3, 16'h3C00, k);
    done_q.push_back(k + 500);

    // Drain scoreboard with a bounded wait
    guard = 0;
    while ((byte_q.size() != 0 || done_q.size() != 0) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", 32'(guard < 2000), 32'd1);
    check("bytes_left", 32'(byte_q.size()), 32'd0);
    check("done_left", 32'(done_q.size()), 32'd0);
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
